// File: rtl/aes_pkg.sv
// Shared AES definitions: S-boxes, GF(2^8) helpers, round count, state type, FSM codes.
package aes_pkg;

  typedef logic [3:0][3:0][7:0] state_t;  // [3-col][3-row][bit]; byte 0 sits in the MSBs

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // MixColumns / InvMixColumns circulant row coefficients, first coefficient in the MSBs
  localparam logic [31:0] MIX_COEF     = 32'h02030101;
  localparam logic [31:0] INV_MIX_COEF = 32'h0e0b0d09;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 32'd6;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One full AES round, forward or inverse, shared by both modes; purely combinational.
module aes_round
  import aes_pkg::*;
(
  input  state_t i_state,
  input  state_t i_round_key,
  input  logic   i_decrypt,
  input  logic   i_last,
  output state_t o_state_c
);

  logic [7:0] w_sh   [4][4];  // [row][col] after (Inv)SubBytes and (Inv)ShiftRows
  logic [7:0] w_pre  [4][4];
  logic [7:0] w_mix  [4][4];
  logic [7:0] w_imix [4][4];
  logic [7:0] w_post;

  // Sub/shift first; decrypt adds the key before InvMixColumns, encrypt after MixColumns.
  always_comb begin
    w_sh      = '{default: 8'h00};
    w_pre     = '{default: 8'h00};
    w_mix     = '{default: 8'h00};
    w_imix    = '{default: 8'h00};
    w_post    = 8'h00;
    o_state_c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (i_decrypt) w_sh[r][c] = inv_sub_byte(i_state[3 - ((c - r) & 3)][3 - r]);
        else           w_sh[r][c] = sub_byte(i_state[3 - ((c + r) & 3)][3 - r]);
        w_pre[r][c] = i_decrypt ? (w_sh[r][c] ^ i_round_key[3 - c][3 - r]) : w_sh[r][c];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          w_mix[r][c]  = w_mix[r][c]  ^ gmul(w_pre[j][c], MIX_COEF[31 - 8 * ((j - r) & 3) -: 8]);
          w_imix[r][c] = w_imix[r][c] ^ gmul(w_pre[j][c], INV_MIX_COEF[31 - 8 * ((j - r) & 3) -: 8]);
        end
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (i_last)         w_post = w_pre[r][c];
        else if (i_decrypt) w_post = w_imix[r][c];
        else                w_post = w_mix[r][c];
        o_state_c[3 - c][3 - r] = i_decrypt ? w_post : (w_post ^ i_round_key[3 - c][3 - r]);
      end
    end
  end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/192/256 Cipher/InvCipher, one round per clock, valid/ready on both sides.
// Optional macro AES_KEY_LATCH_EN: capture w at accept so it may change during the rounds.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter  int unsigned Nk = 8,
  localparam int unsigned Nr = nr_of(Nk)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [128*(Nr+1)-1:0] w,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic                  in_decrypt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data
);

  localparam int unsigned KW  = 128 * (Nr + 1);
  localparam int          NRK = int'(Nr) + 1;

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_iter_cipher: Nk must be 4, 6 or 8");
  end

  logic [1:0]    r_fsm;
  logic [1:0]    w_fsm_nxt;
  logic [3:0]    r_round_cnt;
  logic [127:0]  r_data;
  logic [127:0]  r_out_data;
  logic          r_decrypt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_accept;
  logic          w_last;
  logic [3:0]    w_rk_idx;
  logic [127:0]  w_rk_sel;
  logic [127:0]  w_round_out;
  logic [KW-1:0] w_keys;
  logic [127:0]  w_rk [NRK];

`ifdef AES_KEY_LATCH_EN
  logic [KW-1:0] r_w;

  // Private copy of the schedule, taken on the accept edge
  always_ff @(posedge clk) begin
    if (w_accept) r_w <= w;
  end
  assign w_keys = r_w;
`else
  assign w_keys = w;
`endif

  for (genvar r = 0; r < NRK; r++) begin : g_rk
    assign w_rk[r] = w_keys[KW - 1 - 128 * r -: 128];
  end

  assign w_accept = in_valid & (r_fsm == ST_IDLE);
  assign w_last   = (r_round_cnt == 4'(Nr));
  assign w_rk_idx = r_decrypt ? (4'(Nr) - r_round_cnt) : r_round_cnt;
  assign w_rk_sel = w_rk[w_rk_idx];

  aes_round u_round (
    .i_state     (r_data),
    .i_round_key (w_rk_sel),
    .i_decrypt   (r_decrypt),
    .i_last      (w_last),
    .o_state_c   (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: if (in_valid)  w_fsm_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_fsm_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_fsm_nxt = ST_IDLE;
      default:                w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Datapath: initial AddRoundKey on accept, then one round per cycle until the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_round_cnt <= 4'd0;
      r_data      <= 128'd0;
      r_out_data  <= 128'd0;
      r_decrypt   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_fsm_nxt == ST_IDLE);
      r_out_valid <= (w_fsm_nxt == ST_DONE);
      if (w_accept) begin
        r_data      <= in_data ^ (in_decrypt ? w[127:0] : w[KW-1 -: 128]);
        r_decrypt   <= in_decrypt;
        r_round_cnt <= 4'd1;
      end else if (r_fsm == ST_RUN) begin
        if (w_last) begin
          r_out_data <= w_round_out;
        end else begin
          r_data      <= w_round_out;
          r_round_cnt <= r_round_cnt + 4'd1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: one instance per key size, cycle model plus FIPS-197 vectors.
module tb_aes_iter_cipher;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk;
  logic          rst;
  logic          in_valid   [3];
  logic          in_decrypt [3];
  logic          out_ready  [3];
  logic [127:0]  in_data    [3];
  logic [1919:0] w_bus      [3];
  logic          in_ready   [3];
  logic          out_valid  [3];
  logic [127:0]  out_data   [3];

  logic [7:0]    tb_sbox  [256];
  logic [7:0]    tb_isbox [256];
  logic [31:0]   tb_words [3][60];

  int            m_phase [3];  // 0 idle, 1 busy, 2 result held
  int            m_left  [3];
  logic [127:0]  m_res   [3];
  logic [127:0]  m_out   [3];

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NKG = 4 + 2 * g;
    aes_iter_cipher #(.Nk(NKG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .w          (w_bus[g][128*(NKG+7)-1:0]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .in_decrypt (in_decrypt[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // GF(2^8) product by carry-less multiply then polynomial reduction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  // S-box from multiplicative inverse and the affine map
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      tb_sbox[a]  = s;
      tb_isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
  endfunction

  task automatic expand(input int k, input logic [255:0] key, input int nk);
    int nw;
    logic [31:0] t;
    logic [7:0] rc;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) tb_words[k][i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = tb_words[k][i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      tb_words[k][i] = tb_words[k][i - nk] ^ t;
    end
    w_bus[k] = '0;
    for (int i = 0; i < nw; i++) w_bus[k][32 * nw - 1 - 32 * i -: 32] = tb_words[k][i];
  endtask

  function automatic logic [7:0] rk(input int k, input int r, input int n);
    logic [31:0] wd;
    wd = tb_words[k][4 * r + n / 4];
    return wd[31 - 8 * (n % 4) -: 8];
  endfunction

  // FIPS-197 Cipher / InvCipher on a 16-byte array, byte n = row n%4, column n/4
  function automatic logic [127:0] aes_model(input int k, input logic [127:0] din, input bit dec);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] dout;
    int nr;
    nr = 10 + 2 * k;
    for (int n = 0; n < 16; n++) s[n] = din[127 - 8 * n -: 8];
    if (!dec) begin
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk(k, 0, n);
      for (int rnd = 1; rnd <= nr; rnd++) begin
        for (int n = 0; n < 16; n++) t[n] = tb_sbox[s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
        for (int n = 0; n < 16; n++) begin
          int c, r;
          c = n / 4; r = n % 4;
          s[n] = (rnd == nr) ? t[n] :
                 gm(8'h02, t[4*c + r]) ^ gm(8'h03, t[4*c + (r+1)%4]) ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
        end
        for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk(k, rnd, n);
      end
    end else begin
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk(k, nr, n);
      for (int rnd = nr - 1; rnd >= 0; rnd--) begin
        for (int n = 0; n < 16; n++)
          t[n] = tb_isbox[s[(n % 4) + 4 * (((n / 4) - (n % 4) + 4) % 4)]] ^ rk(k, rnd, n);
        for (int n = 0; n < 16; n++) begin
          int c, r;
          c = n / 4; r = n % 4;
          s[n] = (rnd == 0) ? t[n] :
                 gm(8'h0e, t[4*c + r]) ^ gm(8'h0b, t[4*c + (r+1)%4]) ^
                 gm(8'h0d, t[4*c + (r+2)%4]) ^ gm(8'h09, t[4*c + (r+3)%4]);
        end
      end
    end
    for (int n = 0; n < 16; n++) dout[127 - 8 * n -: 8] = s[n];
    return dout;
  endfunction

  // Cycle model: advance on each rising edge, compare on the falling edge
  initial begin : compare
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          m_phase[k] = 0;
          m_out[k]   = '0;
        end else if (m_phase[k] == 0) begin
          if (in_valid[k]) begin
            m_phase[k] = 1;
            m_left[k]  = 10 + 2 * k;
            m_res[k]   = aes_model(k, in_data[k], in_decrypt[k]);
          end
        end else if (m_phase[k] == 1) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_phase[k] = 2;
            m_out[k]   = m_res[k];
          end
        end else if (out_ready[k]) begin
          m_phase[k] = 0;
        end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("in_ready[%0d]", k),  128'(in_ready[k]),  128'(m_phase[k] == 0));
        check($sformatf("out_valid[%0d]", k), 128'(out_valid[k]), 128'(m_phase[k] == 2));
        check($sformatf("out_data[%0d]", k),  out_data[k],        m_out[k]);
      end
    end
  end

  task automatic start(input int k, input logic [127:0] d, input bit dec);
    in_valid[k]   = 1'b1;
    in_data[k]    = d;
    in_decrypt[k] = dec;
  endtask

  // Call in the accept cycle; returns in the first cycle with out_valid high
  task automatic wait_done(input int k, input string name, input logic [127:0] exp, input bit zero_w);
    int n;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    n = 1;
    if (zero_w) w_bus[k] = '0;
    while (!out_valid[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 128'(n), 128'(11 + 2 * k));
    check({name, "_data"}, out_data[k], exp);
  endtask

  task automatic take(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]   = 1'b0;
      in_decrypt[k] = 1'b0;
      out_ready[k]  = 1'b0;
      in_data[k]    = '0;
    end
    build_sbox();
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    check("model_rk10", {tb_words[0][40], tb_words[0][41], tb_words[0][42], tb_words[0][43]},
          128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_c1",     aes_model(0, PT, 1'b0),  CT1);
    check("model_c2",     aes_model(1, CT2, 1'b1), PT);
    check("model_c3_dec", aes_model(2, CT3, 1'b1), PT);
    check("model_c3_enc", aes_model(2, PT, 1'b0),  CT3);

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  128'(in_ready[0]),  128'd1);
    check("reset_out_valid", 128'(out_valid[0]), 128'd0);
    check("reset_out_data",  out_data[2],        128'd0);
    rst = 1'b0;

    start(0, PT, 1'b0);  wait_done(0, "c1_enc", CT1, 1'b0); take(0);
    start(1, CT2, 1'b1); wait_done(1, "c2_dec", PT, 1'b0);  take(1);
    start(2, CT3, 1'b1); wait_done(2, "c3_dec", PT, 1'b0);  take(2);
    start(2, PT, 1'b0);  wait_done(2, "c3_enc", CT3, 1'b0); take(2);

    // Held result under backpressure, then release with a new block offered in the same cycle
    start(0, PT, 1'b0);  wait_done(0, "bp_enc", CT1, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    check("bp_out_valid", 128'(out_valid[0]), 128'd1);
    check("bp_in_ready",  128'(in_ready[0]),  128'd0);
    check("bp_out_data",  out_data[0],        CT1);
    out_ready[0] = 1'b1;
    start(0, CT1, 1'b1);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("b2b_idle_in_ready",  128'(in_ready[0]),  128'd1);
    check("b2b_idle_out_valid", 128'(out_valid[0]), 128'd0);
    wait_done(0, "b2b_dec", PT, 1'b0);
    take(0);

    // Abort in round 5, then a clean block
    start(0, PT, 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 128'(out_valid[0]), 128'd0);
    check("abort_in_ready",  128'(in_ready[0]),  128'd1);
    check("abort_out_data",  out_data[0],        128'd0);
    start(0, PT, 1'b0);  wait_done(0, "abort_c1", CT1, 1'b0); take(0);

`ifdef AES_KEY_LATCH_EN
    start(0, PT, 1'b0);  wait_done(0, "latch_c1", CT1, 1'b1); take(0);
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
